// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: buffers ALU commands in a small FIFO and drives them
// one at a time into an external combinational ALU. It returns each result
// in command order over a valid/ready response channel. Illegal opcodes and
// div/rem by zero are screened, so an undefined ALU output never reaches
// rsp_data.
module alu_cmd_sequencer #(
  parameter int DATA_W = 8,
  parameter int OP_W   = 3,
  parameter int DEPTH  = 4   // power of two, >= 2
) (
  input  logic                     clk,
  input  logic                     rst,
  // command channel
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [OP_W-1:0]          cmd_op,
  input  logic [DATA_W-1:0]        cmd_a,
  input  logic [DATA_W-1:0]        cmd_b,
  // ALU interface
  output logic [DATA_W-1:0]        alu_a,
  output logic [DATA_W-1:0]        alu_b,
  output logic [OP_W-1:0]          alu_operation,
  input  logic [DATA_W-1:0]        alu_result,
  // response channel
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_W-1:0]        rsp_data,
  output logic                     rsp_err,
  output logic [OP_W-1:0]          rsp_op,
  // status
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  localparam logic [OP_W-1:0] OP_DIV = OP_W'(3);
  localparam logic [OP_W-1:0] OP_REM = OP_W'(4);

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    ISSUE       = 2'd1,
    CAPTURE_RSP = 2'd2
  } state_t;

  cmd_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  state_t           state;
  logic             err_pend;

  cmd_t             head;
  logic             head_err;
  logic             push;
  logic             pop;

  // Full check looks only at the registered count, so a pop in the same
  // cycle never opens a slot early.
  assign cmd_ready  = !rst && (count < CNT_W'(DEPTH));
  assign push       = cmd_valid && cmd_ready;
  assign pop        = (state == IDLE) && (count != '0);
  assign head       = mem[rd_ptr];
  assign fifo_count = count;

  // Commands the ALU cannot compute defined results for: reserved opcodes
  // above rem, and div/rem with a zero divisor.
  assign head_err = (head.op > OP_REM) ||
                    (((head.op == OP_DIV) || (head.op == OP_REM)) && (head.b == '0));

  // FIFO storage: write the incoming command at the tail.
  // NOTE: the storage array has no reset; the valid-entry count is the only
  // thing that must be cleared, and resetting the array would cost a mux per bit.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{op: cmd_op, a: cmd_a, b: cmd_b};
    end
  end

  // FIFO pointers and occupancy; the pointers wrap naturally at DEPTH.
  // NOTE: sequential state uses non-blocking assignments, so every register
  // here sees pre-edge values and the update order does not matter.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Issue FSM: pop one command and present it to the ALU for a full cycle.
  // Then capture the result and hold it until downstream takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      err_pend      <= 1'b0;
      alu_a         <= '0;
      alu_b         <= '0;
      alu_operation <= '0;
      rsp_valid     <= 1'b0;
      rsp_data      <= '0;
      rsp_err       <= 1'b0;
      rsp_op        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (count != '0) begin
            alu_a         <= head.a;
            alu_b         <= head.b;
            alu_operation <= head.op;
            err_pend      <= head_err;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          rsp_data  <= err_pend ? '0 : alu_result;
          rsp_err   <= err_pend;
          rsp_op    <= alu_operation;
          rsp_valid <= 1'b1;
          state     <= CAPTURE_RSP;
        end
        CAPTURE_RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer. A small behavioural ALU closes the
// loop. Inputs are driven, and outputs sampled, 1 time unit after each
// rising edge.
module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = '0;
  logic [7:0] cmd_a = '0;
  logic [7:0] cmd_b = '0;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [2:0] alu_operation;
  logic [7:0] alu_result;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic [2:0] rsp_op;
  logic [2:0] fifo_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.DATA_W(8), .OP_W(3), .DEPTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_a         (cmd_a),
    .cmd_b         (cmd_b),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_operation (alu_operation),
    .alu_result    (alu_result),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .rsp_err       (rsp_err),
    .rsp_op        (rsp_op),
    .fifo_count    (fifo_count)
  );

  // Behavioural ALU. 8'hEE stands in for the real ALU's undefined output,
  // so a leak of that value onto rsp_data is visible.
  always_comb begin
    alu_result = 8'hEE;
    case (alu_operation)
      3'd0: alu_result = alu_a + alu_b;
      3'd1: alu_result = alu_a - alu_b;
      3'd2: alu_result = alu_a * alu_b;
      3'd3: if (alu_b != 0) alu_result = alu_a / alu_b;
      3'd4: if (alu_b != 0) alu_result = alu_a % alu_b;
      default: alu_result = 8'hEE;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    step(); step(); step();
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++; $display("FAIL reset_cmd_ready: got %b expected 0", cmd_ready);
    end
    checks++;
    if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_data !== 8'h00 || rsp_op !== 3'd0) begin
      errors++;
      $display("FAIL reset_rsp: got valid=%b err=%b data=%h op=%0d expected all zero",
               rsp_valid, rsp_err, rsp_data, rsp_op);
    end
    checks++;
    if (alu_a !== 8'h00 || alu_b !== 8'h00 || alu_operation !== 3'd0 || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL reset_alu_count: got a=%h b=%h op=%0d count=%0d expected all zero",
               alu_a, alu_b, alu_operation, fifo_count);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready: got %b expected 1", cmd_ready);
    end
  endtask

  task automatic test_single_add();
    rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_op = 3'd0; cmd_a = 8'd200; cmd_b = 8'd100;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL add_ready: got %b expected 1", cmd_ready);
    end
    step();                                   // accept edge E0
    cmd_valid = 1'b0;
    checks++;
    if (fifo_count !== 3'd1 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL add_queued: got count=%0d valid=%b expected 1 0", fifo_count, rsp_valid);
    end
    step();                                   // pop edge E1, now in ISSUE
    checks++;
    if (alu_a !== 8'd200 || alu_b !== 8'd100 || alu_operation !== 3'd0 ||
        fifo_count !== 3'd0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL add_issue: got a=%0d b=%0d op=%0d count=%0d valid=%b expected 200 100 0 0 0",
               alu_a, alu_b, alu_operation, fifo_count, rsp_valid);
    end
    step();                                   // capture edge E2
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 8'h2C || rsp_err !== 1'b0 || rsp_op !== 3'd0) begin
      errors++;
      $display("FAIL add_rsp: got valid=%b data=%h err=%b op=%0d expected 1 2c 0 0",
               rsp_valid, rsp_data, rsp_err, rsp_op);
    end
    step();                                   // response taken
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL add_rsp_clear: got valid=%b expected 0", rsp_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] ops [4];
    logic [7:0] as  [4];
    logic [7:0] bs  [4];
    logic [7:0] exp [4];
    int got;
    int last;
    ops[0] = 3'd1; as[0] = 8'd5;   bs[0] = 8'd10; exp[0] = 8'hFB;
    ops[1] = 3'd2; as[1] = 8'd20;  bs[1] = 8'd13; exp[1] = 8'h04;
    ops[2] = 3'd3; as[2] = 8'd100; bs[2] = 8'd7;  exp[2] = 8'd14;
    ops[3] = 3'd4; as[3] = 8'd100; bs[3] = 8'd7;  exp[3] = 8'd2;
    got = 0;
    last = 0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 40 && got < 4; i++) begin
      if (rsp_valid === 1'b1) begin
        checks++;
        if (rsp_data !== exp[got] || rsp_err !== 1'b0 || rsp_op !== ops[got]) begin
          errors++;
          $display("FAIL b2b_rsp%0d: got data=%h err=%b op=%0d expected %h 0 %0d",
                   got, rsp_data, rsp_err, rsp_op, exp[got], ops[got]);
        end
        checks++;
        if (got == 0 && i != 3) begin
          errors++; $display("FAIL b2b_latency: got cycle %0d expected 3", i);
        end else if (got > 0 && (i - last) != 3) begin
          errors++; $display("FAIL b2b_spacing%0d: got %0d cycles expected 3", got, i - last);
        end
        last = i;
        got++;
      end
      if (i < 4) begin
        cmd_valid = 1'b1; cmd_op = ops[i]; cmd_a = as[i]; cmd_b = bs[i];
        checks++;
        if (cmd_ready !== 1'b1) begin
          errors++; $display("FAIL b2b_ready%0d: got %b expected 1", i, cmd_ready);
        end
      end else begin
        cmd_valid = 1'b0;
      end
      step();
    end
    cmd_valid = 1'b0;
    checks++;
    if (got != 4) begin
      errors++; $display("FAIL b2b_count: got %0d responses expected 4", got);
    end
  endtask

  task automatic test_errors();
    logic [2:0] ops [2];
    logic [7:0] as  [2];
    logic [7:0] bs  [2];
    int got;
    ops[0] = 3'd3; as[0] = 8'd9; bs[0] = 8'd0;
    ops[1] = 3'd5; as[1] = 8'd1; bs[1] = 8'd1;
    got = 0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 30 && got < 2; i++) begin
      if (rsp_valid === 1'b1) begin
        checks++;
        if (rsp_data !== 8'h00 || rsp_err !== 1'b1 || rsp_op !== ops[got]) begin
          errors++;
          $display("FAIL err_rsp%0d: got data=%h err=%b op=%0d expected 00 1 %0d",
                   got, rsp_data, rsp_err, rsp_op, ops[got]);
        end
        got++;
      end
      if (i < 2) begin
        cmd_valid = 1'b1; cmd_op = ops[i]; cmd_a = as[i]; cmd_b = bs[i];
      end else begin
        cmd_valid = 1'b0;
      end
      step();
    end
    cmd_valid = 1'b0;
    checks++;
    if (got != 2) begin
      errors++; $display("FAIL err_count: got %0d responses expected 2", got);
    end
  endtask

  // Six add commands (a=k, b=10k, result 11k) against a stalled response.
  task automatic test_backpressure_full();
    int got;
    rsp_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cmd_valid = 1'b1; cmd_op = 3'd0; cmd_a = 8'(i + 1); cmd_b = 8'(10 * (i + 1));
      checks++;
      if (cmd_ready !== (i < 5)) begin
        errors++; $display("FAIL full_ready%0d: got %b expected %b", i, cmd_ready, (i < 5));
      end
      if (i >= 3) begin
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 8'd11 || rsp_err !== 1'b0 || rsp_op !== 3'd0) begin
          errors++;
          $display("FAIL stall_hold%0d: got valid=%b data=%0d err=%b op=%0d expected 1 11 0 0",
                   i, rsp_valid, rsp_data, rsp_err, rsp_op);
        end
      end
      step();
    end
    // Sixth command held valid while the FIFO is full.
    checks++;
    if (fifo_count !== 3'd4 || cmd_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_data !== 8'd11) begin
      errors++;
      $display("FAIL full_state: got count=%0d ready=%b valid=%b data=%0d expected 4 0 1 11",
               fifo_count, cmd_ready, rsp_valid, rsp_data);
    end
    rsp_ready = 1'b1;
    step();                                   // first response taken, FSM to IDLE
    checks++;
    if (rsp_valid !== 1'b0 || fifo_count !== 3'd4 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_pop_cycle: got valid=%b count=%0d ready=%b expected 0 4 0",
               rsp_valid, fifo_count, cmd_ready);
    end
    step();                                   // pop, no push
    checks++;
    if (fifo_count !== 3'd3 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL full_after_pop: got count=%0d ready=%b expected 3 1", fifo_count, cmd_ready);
    end
    step();                                   // held command pushed
    cmd_valid = 1'b0;
    checks++;
    if (fifo_count !== 3'd4) begin
      errors++; $display("FAIL full_refill: got count=%0d expected 4", fifo_count);
    end
    got = 0;
    for (int i = 0; i < 40 && got < 5; i++) begin
      if (rsp_valid === 1'b1) begin
        checks++;
        if (rsp_data !== 8'(11 * (got + 2)) || rsp_err !== 1'b0 || rsp_op !== 3'd0) begin
          errors++;
          $display("FAIL drain_rsp%0d: got data=%0d err=%b op=%0d expected %0d 0 0",
                   got, rsp_data, rsp_err, rsp_op, 11 * (got + 2));
        end
        got++;
      end
      step();
    end
    checks++;
    if (got != 5 || fifo_count !== 3'd0) begin
      errors++; $display("FAIL drain_count: got %0d responses count=%0d expected 5 0", got, fifo_count);
    end
  endtask

  task automatic test_reset_mid();
    int stale;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cmd_valid = 1'b1; cmd_op = 3'd0; cmd_a = 8'(2 * i + 1); cmd_b = 8'(2 * i + 2);
      if (i == 3) begin
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 8'd3) begin
          errors++; $display("FAIL mid_first_rsp: got valid=%b data=%0d expected 1 3", rsp_valid, rsp_data);
        end
      end
      step();
    end
    cmd_valid = 1'b0;
    step();                                   // second command popped, FSM in ISSUE
    checks++;
    if (fifo_count !== 3'd2 || alu_a !== 8'd3 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_issue_state: got count=%0d alu_a=%0d valid=%b expected 2 3 0",
               fifo_count, alu_a, rsp_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++; $display("FAIL mid_rst_ready: got %b expected 0", cmd_ready);
    end
    step();
    checks++;
    if (rsp_valid !== 1'b0 || fifo_count !== 3'd0 || alu_a !== 8'd0) begin
      errors++;
      $display("FAIL mid_rst_state: got valid=%b count=%0d alu_a=%0d expected 0 0 0",
               rsp_valid, fifo_count, alu_a);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL mid_release_ready: got %b expected 1", cmd_ready);
    end
    stale = 0;
    for (int i = 0; i < 12; i++) begin
      if (rsp_valid !== 1'b0) stale++;
      step();
    end
    checks++;
    if (stale != 0 || fifo_count !== 3'd0) begin
      errors++; $display("FAIL mid_stale_rsp: got %0d stale cycles count=%0d expected 0 0", stale, fifo_count);
    end
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_back_to_back();
    test_errors();
    test_backpressure_full();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1);
  end

endmodule
